// File: rtl/can_bit_destuff.sv
// CAN bit-level destuffer: samples the bus once per bit at mid-bit, hard-resyncs
// on recessive-to-dominant edges, drops stuff bits in the stuffed region, flags
// stuff violations and detects the seven-recessive end of frame in the tail.
module can_bit_destuff #(
    parameter int clk_speed_MHz      = 100,
    parameter int can_bit_rate_Kbits = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic can_rx,
    input  logic sof_detect,
    input  logic stuff_en,
    output logic bit_out,
    output logic bit_valid,
    output logic stuff_err,
    output logic frame_end,
    output logic frame_active
);

    localparam int BP   = (clk_speed_MHz * 1000) / can_bit_rate_Kbits;
    localparam int HALF = BP / 2;
    localparam int TQW  = (BP > 1) ? $clog2(BP) : 1;

    localparam logic [TQW-1:0] TQ_LAST = TQW'(BP - 1);
    localparam logic [TQW-1:0] TQ_HALF = TQW'(HALF);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          r_state;
    logic [TQW-1:0]  r_tq_cnt;
    logic [2:0]      r_run_len;
    logic [2:0]      r_rec_cnt;
    logic            r_last_bit;
    logic            r_prev_rx;

    logic            w_resync;
    logic [TQW-1:0]  w_tq_next;
    logic            w_sample;
    logic            w_same;
    logic            w_stuff;
    logic [2:0]      w_run_next;
    logic [2:0]      w_rec_next;

    // Next bit-timer value, sample strobe and run/recessive bookkeeping.
    // The sample is taken in the cycle the timer is loaded with HALF, which puts
    // the SOF sample HALF-1 cycles after sof_detect (timer starts at 1 there).
    always_comb begin
        w_resync   = r_prev_rx & ~can_rx;
        w_tq_next  = '0;
        if (!w_resync && (r_tq_cnt != TQ_LAST)) begin
            w_tq_next = r_tq_cnt + TQW'(1);
        end
        w_sample   = (r_state == ST_RUN) && (w_tq_next == TQ_HALF);
        w_same     = (can_rx == r_last_bit);
        w_stuff    = stuff_en && (r_run_len == 3'd5);
        w_run_next = 3'd1;
        if (w_same) begin
            w_run_next = (r_run_len == 3'd7) ? 3'd7 : r_run_len + 3'd1;
        end
        w_rec_next = '0;
        if (!stuff_en && can_rx) begin
            w_rec_next = r_rec_cnt + 3'd1;
        end
    end

    // Two-state frame FSM with registered data and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tq_cnt     <= '0;
            r_run_len    <= '0;
            r_rec_cnt    <= '0;
            r_last_bit   <= 1'b1;
            r_prev_rx    <= 1'b1;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            stuff_err    <= 1'b0;
            frame_end    <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            r_prev_rx <= can_rx;
            bit_valid <= 1'b0;
            stuff_err <= 1'b0;
            frame_end <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sof_detect) begin
                        r_state      <= ST_RUN;
                        frame_active <= 1'b1;
                        r_tq_cnt     <= TQW'(1);
                        r_run_len    <= '0;
                        r_rec_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_tq_cnt <= w_tq_next;
                    if (w_sample) begin
                        if (w_stuff) begin
                            r_rec_cnt <= '0;
                            if (w_same) begin
                                stuff_err    <= 1'b1;
                                r_state      <= ST_IDLE;
                                frame_active <= 1'b0;
                            end else begin
                                r_run_len  <= 3'd1;
                                r_last_bit <= can_rx;
                            end
                        end else begin
                            bit_out    <= can_rx;
                            bit_valid  <= 1'b1;
                            r_run_len  <= w_run_next;
                            r_last_bit <= can_rx;
                            r_rec_cnt  <= w_rec_next;
                            if (!stuff_en && (w_rec_next == 3'd7)) begin
                                frame_end    <= 1'b1;
                                r_state      <= ST_IDLE;
                                frame_active <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    frame_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_bit_destuff.sv
// Scoreboard bench for can_bit_destuff: a bit-level reference model predicts the
// delivered bits / error / end-of-frame events; a monitor compares them.
module tb_can_bit_destuff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic can_rx = 1'b1;
    logic sof_detect = 1'b0;
    logic stuff_en = 1'b0;
    logic bit_out, bit_valid, stuff_err, frame_end, frame_active;

    always #5 clk = ~clk;

    can_bit_destuff #(
        .clk_speed_MHz     (100),
        .can_bit_rate_Kbits(1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .can_rx      (can_rx),
        .sof_detect  (sof_detect),
        .stuff_en    (stuff_en),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .stuff_err   (stuff_err),
        .frame_end   (frame_end),
        .frame_active(frame_active)
    );

    typedef struct {
        bit          err;
        bit          b;
        bit          fend;
        bit          first;
        int unsigned t;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    bit          fb[128];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [4:0] a, input logic [4:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%b exp=%b", nm, a, e);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    initial begin : monitor
        logic [4:0] act, expv, mask;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bit_valid || stuff_err || frame_end) begin
                act = {bit_valid, bit_out, stuff_err, frame_end, frame_active};
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse act=%b exp=none", act);
                end else begin
                    e = sbq.pop_front();
                    if (e.err) begin
                        expv = 5'b00100;
                        mask = 5'b10111;
                    end else begin
                        expv = {1'b1, e.b, 1'b0, e.fend, ~e.fend};
                        mask = 5'b11111;
                    end
                    if ((act & mask) !== (expv & mask)) begin
                        bad++;
                        $display("FAIL event act=%b exp=%b mask=%b", act, expv, mask);
                    end
                    if (e.first) begin
                        total++;
                        if (cyc != e.t) begin
                            bad++;
                            $display("FAIL first_bit_time act=%0d exp=%0d", cyc, e.t);
                        end
                    end
                end
            end
        end
    end

    // Bit-level reference: apply the destuffing rules to the transmitted bit list.
    task automatic model(input int nb, input int nstuff, input int limit, input int unsigned t0);
        int   run, rec, cnt;
        bit   last, s, se;
        exp_t e;
        run = 0; rec = 0; last = 1'b1; cnt = 0;
        for (int k = 0; k < nb && cnt < limit; k++) begin
            s  = fb[k];
            se = (k < nstuff);
            e.first = (cnt == 0); e.t = t0; e.err = 1'b0; e.b = s; e.fend = 1'b0;
            if (se && run == 5) begin
                if (s == last) begin
                    e.err = 1'b1;
                    sbq.push_back(e);
                    return;
                end
                run = 1; last = s; rec = 0;
                continue;
            end
            run  = (s == last) ? ((run < 7) ? run + 1 : 7) : 1;
            last = s;
            rec  = se ? 0 : (s ? rec + 1 : 0);
            if (rec == 7) e.fend = 1'b1;
            sbq.push_back(e);
            cnt++;
            if (e.fend) return;
        end
    endtask

    task automatic load(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) fb[i] = v[n-1-i];
    endtask

    task automatic gen_random(output int nb, output int nstuff);
        int run, len, tl;
        bit last, b;
        fb[0] = 1'b0; nb = 1; last = 1'b0; run = 1;
        len = $urandom_range(25, 8);
        for (int i = 0; i < len; i++) begin
            if (run == 5) begin
                b = ($urandom_range(7) == 0) ? last : ~last;
                fb[nb++] = b;
                run = 1; last = b;
                continue;
            end
            b = ($urandom_range(3) != 0) ? last : ~last;
            fb[nb++] = b;
            run  = (b == last) ? run + 1 : 1;
            last = b;
        end
        nstuff = nb;
        tl = $urandom_range(6);
        for (int i = 0; i < tl; i++) fb[nb++] = 1'($urandom_range(1));
        for (int i = 0; i < 7; i++) fb[nb++] = 1'b1;
    endtask

    task automatic run_frame(input int nb, input int nstuff, input bit skew,
                             input bit glitch, input int abort_at);
        int st[128];
        int idx, m;
        st[0] = 0;
        for (int k = 1; k < nb; k++)
            st[k] = 100 * k + (skew ? int'($urandom_range(20)) - 10 : 0);
        @(posedge clk);
        #1;
        model(nb, nstuff, (abort_at >= 0) ? 1 : 1000, cyc + 50);
        sof_detect = 1'b1;
        can_rx     = fb[0];
        stuff_en   = (nstuff > 0);
        idx = 0;
        for (int n = 0; n < nb * 100; n++) begin
            @(posedge clk);
            if (n == abort_at) begin
                #3 rst = 1'b1; sof_detect = 1'b1;
                #1 chk("abort_outputs", {bit_valid, bit_out, stuff_err, frame_end, frame_active}, 5'b0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b0; sof_detect = 1'b0; can_rx = 1'b1; stuff_en = 1'b0;
                repeat (5) @(posedge clk);
                #1 chk("sof_ignored_in_rst", {4'b0, frame_active}, 5'b0);
                return;
            end
            #1;
            sof_detect = 1'b0;
            m = n + 1;
            while (idx + 1 < nb && m >= st[idx+1]) idx++;
            can_rx = fb[idx];
            if (m / 100 < nstuff) stuff_en = 1'b1;
            else stuff_en = glitch && (m % 100 >= 80) && (m % 100 < 90);
        end
        can_rx = 1'b1; stuff_en = 1'b0; sof_detect = 1'b0;
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int nb, ns;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {bit_valid, bit_out, stuff_err, frame_end, frame_active}, 5'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // SOF,0,1,0,1 in stuffed region, then recessive tail
        load(64'b001011111111, 12);
        run_frame(12, 5, 1'b0, 1'b0, -1);
        // five dominant then recessive stuff bit, then 1
        load(64'b00000111111111, 14);
        run_frame(14, 7, 1'b0, 1'b0, -1);
        // sixth dominant bit violates stuffing
        load(64'b0000001111111, 13);
        run_frame(13, 6, 1'b0, 1'b0, -1);
        // SOF then seven recessive in unstuffed tail
        load(64'b01111111, 8);
        run_frame(8, 1, 1'b0, 1'b1, -1);
        // reset mid-frame at tq_cnt = 30 of the second bit, then a clean frame
        load(64'b000101111111, 12);
        run_frame(12, 5, 1'b0, 1'b0, 129);
        load(64'b001011111111, 12);
        run_frame(12, 5, 1'b0, 1'b0, -1);
        for (int f = 0; f < 12; f++) begin
            gen_random(nb, ns);
            run_frame(nb, ns, (f % 3) != 0, f[0], -1);
        end
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain act=%0d exp=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/can_bit_destuff.md
CAN_BIT_DESTUFF -- requirements
Module: can_bit_destuff

Interface
REQ-001 The block SHALL have parameter clk_speed_MHz, default 100, system clock frequency in MHz.
REQ-002 The block SHALL have parameter can_bit_rate_Kbits, default 1000, CAN bit rate in Kbit/s; BP = (clk_speed_MHz*1000)/can_bit_rate_Kbits clocks per bit (100 at defaults), HALF = BP/2.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port can_rx  input  1  CAN bus level (1 = recessive, 0 = dominant), synchronous to clk.
REQ-006 The block SHALL have port sof_detect  input  1  one-cycle start-of-frame pulse from the upstream frame detector.
REQ-007 The block SHALL have port stuff_en  input  1  from the downstream frame parser; 1 = stuffed region (SOF..CRC), 0 = unstuffed tail.
REQ-008 The block SHALL have port bit_out  output  1  destuffed data bit, valid only when bit_valid = 1.
REQ-009 The block SHALL have port bit_valid  output  1  one-cycle strobe per delivered data bit.
REQ-010 The block SHALL have port stuff_err  output  1  one-cycle pulse on stuff-rule violation.
REQ-011 The block SHALL have port frame_end  output  1  one-cycle pulse on end-of-frame detection.
REQ-012 The block SHALL have port frame_active  output  1  high while state = RUN.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE, RUN.
REQ-014 IDLE -> RUN on sof_detect = 1; in that cycle bit timer tq_cnt <= 1, run_len <= 0, rec_cnt <= 0, prev_rx <= can_rx.
REQ-015 sof_detect SHALL be ignored while in RUN.
REQ-016 In RUN, tq_cnt SHALL increment each cycle and wrap from BP-1 to 0; width = $clog2(BP).
REQ-017 Hard resync: in RUN, when prev_rx = 1 and can_rx = 0 (recessive-to-dominant edge), tq_cnt SHALL load 0 that cycle instead of incrementing.
REQ-018 prev_rx SHALL register can_rx every cycle.
REQ-019 Sample point: a bus bit SHALL be sampled from can_rx in the cycle tq_cnt = HALF; first sample (the SOF bit, value 0) occurs HALF-1 cycles after the sof_detect cycle.
REQ-020 Run tracking: on each sample, if sample = last_bit then run_len <= run_len+1 (saturating at 7), else run_len <= 1; last_bit <= sample.
REQ-021 Stuffed region: if stuff_en = 1 and run_len = 5 at a sample, that sample is a stuff bit.
REQ-022 Stuff bit opposite to last_bit: dropped (no bit_valid), run_len <= 1, last_bit <= sample.
REQ-023 Stuff bit equal to last_bit: stuff_err pulses for one cycle, no bit_valid, FSM -> IDLE next cycle.
REQ-024 All non-stuff samples SHALL be delivered: bit_out <= sample, bit_valid = 1 for one cycle, registered one cycle after the sample cycle.
REQ-025 Unstuffed tail: when stuff_en = 0, rec_cnt SHALL count consecutive recessive samples (reset to 0 on a dominant sample); stuff_en = 1 forces rec_cnt <= 0.
REQ-026 When rec_cnt reaches 7 with stuff_en = 0, the 7th bit SHALL be delivered, frame_end pulses in the same cycle as its bit_valid, FSM -> IDLE.
REQ-027 stuff_en SHALL be evaluated at each sample cycle only; changes between samples have no effect.
REQ-028 Pulse outputs SHALL never be high in IDLE except the single cycle completing the transition out of RUN; stuff_err and frame_end SHALL be mutually exclusive.

Reset
REQ-029 While rst = 1: state = IDLE, tq_cnt = 0, run_len = 0, rec_cnt = 0, last_bit = 1, prev_rx = 1, bit_out = 0, bit_valid = 0, stuff_err = 0, frame_end = 0, frame_active = 0.
REQ-030 Reset asserted mid-frame SHALL abort immediately with no further pulses; after release the block waits in IDLE for the next sof_detect.

Verification
REQ-031 sof_detect pulse then bus 0,1,0,1 bits, stuff_en = 1 -> bit_valid pulses at sample+1 cycles, bit_out = 0,0,1,0,1 (SOF included), first sample 49 cycles after sof_detect.
REQ-032 SOF + four dominant bits + recessive stuff bit + 1, stuff_en = 1 -> five delivered 0s, stuff bit dropped, next delivered bit = 1, no stuff_err.
REQ-033 SOF + five dominant bits + sixth dominant bit, stuff_en = 1 -> stuff_err single pulse, frame_active low next cycle, no bit_valid for sixth bit.
REQ-034 stuff_en = 0, seven recessive bits sampled -> seven bit_valid with bit_out = 1, frame_end coincident with seventh, then IDLE.
REQ-035 Bit edges skewed +/-10 clocks with recessive-to-dominant transitions -> all samples still land within the correct bit (resync verified), delivered sequence matches stimulus.
REQ-036 rst asserted at tq_cnt = 30 mid-frame -> all outputs 0 asynchronously; sof_detect ignored only while rst = 1; next frame decodes correctly.
